// File: rtl/credit_link_arbiter.sv
`timescale 1ns/1ps
// Sender-side credit-flow link controller: round-robin arbiter, credit counter and link-reset FSM.
// Optional build macro CREDIT_ARB_PRIORITY_EN makes requester 0 strict priority over the rotating rest.
module credit_link_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CREDIT_MAX = 8,
  parameter int CW         = $clog2(CREDIT_MAX + 1)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            push_valid,
  output logic [DATA_WIDTH-1:0]           push_data,
  output logic                            push_sender_in_reset,
  input  logic                            push_receiver_in_reset,
  input  logic                            push_credit,
  output logic                            push_credit_stall,
  output logic [CW-1:0]                   credit_count,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic [1:0]                      fsm_state
);

  localparam int GW = $clog2(NUM_REQ);

  // Handshake: requester i transfers in the cycle where req_valid[i] & req_ready[i];
  // req_ready is a combinational one-hot grant and never waits on req_valid being stable.
  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                arb_en, prio_hit, rr_hit, gnt, upd_gid;
  logic [NUM_REQ-1:0]  cand, grant_vec;
  logic [GW-1:0]       rr_idx, gnt_idx;
  logic [CW-1:0]       credit_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RESET;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET:  state_nxt = ST_WAIT;
      ST_WAIT:   if (!push_receiver_in_reset) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (push_receiver_in_reset) state_nxt = ST_WAIT;
      default:   state_nxt = ST_RESET;
    endcase
  end

  assign arb_en = (state == ST_ACTIVE) && !push_receiver_in_reset && (credit_count != '0);

  always_comb begin
`ifdef CREDIT_ARB_PRIORITY_EN
    cand     = {req_valid[NUM_REQ-1:1], 1'b0};
    prio_hit = arb_en & req_valid[0];
`else
    cand     = req_valid;
    prio_hit = 1'b0;
`endif
    rr_hit = 1'b0;
    rr_idx = grant_id;
    // Rotating search starts just past the last round-robin winner.
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (arb_en && !rr_hit && cand[(int'(grant_id) + k) % NUM_REQ]) begin
        rr_hit = 1'b1;
        rr_idx = GW'((int'(grant_id) + k) % NUM_REQ);
      end
    end
    gnt       = prio_hit | rr_hit;
    gnt_idx   = prio_hit ? '0 : rr_idx;
    upd_gid   = rr_hit & !prio_hit;
    grant_vec = '0;
    if (gnt) grant_vec[gnt_idx] = 1'b1;
  end

  always_comb begin
    credit_nxt = credit_count;
    if (state == ST_ACTIVE) begin
      if (push_receiver_in_reset)
        credit_nxt = '0;
      else if (!(push_credit && !gnt && credit_count == CW'(CREDIT_MAX)))
        credit_nxt = credit_count + CW'(push_credit) - CW'(gnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_count <= '0;
      grant_id     <= GW'(NUM_REQ - 1);
      push_valid   <= 1'b0;
      push_data    <= '0;
    end else begin
      credit_count <= credit_nxt;
      push_valid   <= gnt;
      if (upd_gid) grant_id  <= gnt_idx;
      if (gnt)     push_data <= req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign req_ready            = grant_vec;
  assign push_sender_in_reset = (state == ST_RESET);
  assign push_credit_stall    = (state == ST_ACTIVE) && (credit_count == CW'(CREDIT_MAX));
  assign fsm_state            = state;

endmodule

// File: tb/tb_credit_link_arbiter.sv
`timescale 1ns/1ps
// Bench for credit_link_arbiter: directed vector table, hand sequences and a randomized
// run against a cycle-level reference model of the link rules.
module tb_credit_link_arbiter;

  localparam int N    = 4;
  localparam int DW   = 8;
  localparam int CMAX = 8;
  localparam int CW   = $clog2(CMAX + 1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic              push_valid;
  logic [DW-1:0]     push_data;
  logic              push_sender_in_reset;
  logic              push_receiver_in_reset = 1'b0;
  logic              push_credit = 1'b0;
  logic              push_credit_stall;
  logic [CW-1:0]     credit_count;
  logic [1:0]        grant_id;
  logic [1:0]        fsm_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  credit_link_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .CREDIT_MAX(CMAX)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .push_valid(push_valid), .push_data(push_data),
    .push_sender_in_reset(push_sender_in_reset),
    .push_receiver_in_reset(push_receiver_in_reset), .push_credit(push_credit),
    .push_credit_stall(push_credit_stall), .credit_count(credit_count),
    .grant_id(grant_id), .fsm_state(fsm_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] rv; logic cr; logic rx;
    logic [3:0] rdy; int cnt; logic pv; logic [7:0] pd;
    logic stall; logic sir; int st; int gid;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] rv, logic cr, logic rx, logic [3:0] rdy, int cnt,
                              logic pv, logic [7:0] pd, logic stall, logic sir, int st, int gid);
    vec_t v;
    v.rv = rv; v.cr = cr; v.rx = rx; v.rdy = rdy; v.cnt = cnt; v.pv = pv; v.pd = pd;
    v.stall = stall; v.sir = sir; v.st = st; v.gid = gid;
    return v;
  endfunction

  // ---------------- reference model ----------------
  int         m_phase;   // 0 reset, 1 waiting for receiver, 2 active
  int         m_cnt;
  int         m_gid;
  logic       m_pv;
  logic [7:0] m_pd;

  function automatic int pick(logic [3:0] rv, logic rx);
    if (m_phase != 2 || rx || m_cnt == 0) return -1;
`ifdef CREDIT_ARB_PRIORITY_EN
    if (rv[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int i = (m_gid + k) % N;
`ifdef CREDIT_ARB_PRIORITY_EN
      if (i == 0) continue;
`endif
      if (rv[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_cnt = 0; m_gid = N - 1; m_pv = 1'b0; m_pd = '0;
  endtask

  task automatic cycle(input logic [3:0] rv, input logic [31:0] rd, input logic cr,
                       input logic rx, output int g);
    @(negedge clk);
    rst_n = 1'b1; req_valid = rv; req_data = rd; push_credit = cr; push_receiver_in_reset = rx;
    #1;
    g = pick(rv, rx);
    check("ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
    check("credit_count", credit_count, m_cnt);
    check("push_valid", push_valid, m_pv);
    if (m_pv) check("push_data", push_data, m_pd);
    check("stall", push_credit_stall, (m_phase == 2 && m_cnt == CMAX));
    check("sender_in_reset", push_sender_in_reset, (m_phase == 0));
    check("grant_id", grant_id, m_gid);
    check("state", fsm_state, m_phase);
    case (m_phase)
      0: m_phase = 1;
      1: if (!rx) m_phase = 2;
      default: begin
        if (rx) begin
          m_phase = 1; m_cnt = 0;
        end else begin
          m_cnt += int'(cr);
          if (g >= 0) m_cnt--;
          if (m_cnt > CMAX) m_cnt = CMAX;
        end
      end
    endcase
    m_pv = (g >= 0);
    if (g >= 0) begin
      m_pd = rd[g*DW +: DW];
`ifdef CREDIT_ARB_PRIORITY_EN
      if (g != 0) m_gid = g;
`else
      m_gid = g;
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_reset_sir", push_sender_in_reset, 1'b1);
    check("async_reset_valid", push_valid, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    logic [31:0] rd;
    // Reset state with requests and credits pending.
    req_valid = 4'b1111; push_credit = 1'b1; req_data = 32'hA3A2A1A0;
    repeat (2) @(negedge clk);
    #1;
    check("rst push_valid", push_valid, 0);
    check("rst push_data", push_data, 0);
    check("rst credit_count", credit_count, 0);
    check("rst grant_id", grant_id, N - 1);
    check("rst sender_in_reset", push_sender_in_reset, 1);
    check("rst stall", push_credit_stall, 0);
    check("rst req_ready", req_ready, 0);
    check("rst state", fsm_state, 0);

`ifndef CREDIT_ARB_PRIORITY_EN
    //           rv      cr rx  rdy     cnt pv pd     st sir st gid
    tbl.push_back(mk(4'b1111, 1, 1, 4'b0000, 0, 0, 8'h00, 0, 1, 0, 3));
    tbl.push_back(mk(4'b1111, 0, 1, 4'b0000, 0, 0, 8'h00, 0, 0, 1, 3));
    tbl.push_back(mk(4'b0000, 1, 1, 4'b0000, 0, 0, 8'h00, 0, 0, 1, 3));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 0, 1, 3));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 0, 2, 3));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 1, 0, 8'h00, 0, 0, 2, 3));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 2, 0, 8'h00, 0, 0, 2, 3));
    tbl.push_back(mk(4'b1111, 0, 0, 4'b0001, 3, 0, 8'h00, 0, 0, 2, 3));
    tbl.push_back(mk(4'b1111, 0, 0, 4'b0010, 2, 1, 8'hA0, 0, 0, 2, 0));
    tbl.push_back(mk(4'b1111, 0, 0, 4'b0100, 1, 1, 8'hA1, 0, 0, 2, 1));
    tbl.push_back(mk(4'b1111, 0, 0, 4'b0000, 0, 1, 8'hA2, 0, 0, 2, 2));
    tbl.push_back(mk(4'b0010, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 0, 2, 2));
    tbl.push_back(mk(4'b0010, 0, 0, 4'b0010, 1, 0, 8'h00, 0, 0, 2, 2));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 0, 1, 8'hA1, 0, 0, 2, 1));
    for (int c = 1; c <= 7; c++)
      tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, c, 0, 8'h00, 0, 0, 2, 1));
    tbl.push_back(mk(4'b0000, 1, 0, 4'b0000, 8, 0, 8'h00, 1, 0, 2, 1));
    tbl.push_back(mk(4'b0100, 1, 0, 4'b0100, 8, 0, 8'h00, 1, 0, 2, 1));
    tbl.push_back(mk(4'b0000, 0, 0, 4'b0000, 8, 1, 8'hA2, 1, 0, 2, 2));
    tbl.push_back(mk(4'b1111, 0, 0, 4'b1000, 8, 0, 8'h00, 1, 0, 2, 2));
    tbl.push_back(mk(4'b1111, 0, 0, 4'b0001, 7, 1, 8'hA3, 0, 0, 2, 3));
    tbl.push_back(mk(4'b1111, 0, 0, 4'b0010, 6, 1, 8'hA0, 0, 0, 2, 0));
    tbl.push_back(mk(4'b1111, 0, 1, 4'b0000, 5, 1, 8'hA1, 0, 0, 2, 1));
    tbl.push_back(mk(4'b1111, 0, 0, 4'b0000, 0, 0, 8'h00, 0, 0, 1, 1));
    tbl.push_back(mk(4'b1111, 1, 0, 4'b0000, 0, 0, 8'h00, 0, 0, 2, 1));
    tbl.push_back(mk(4'b1111, 0, 0, 4'b0100, 1, 0, 8'h00, 0, 0, 2, 1));
    tbl.push_back(mk(4'b0000, 0, 0, 4'b0000, 0, 1, 8'hA2, 0, 0, 2, 2));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst_n = 1'b1; req_valid = tbl[i].rv; req_data = 32'hA3A2A1A0;
      push_credit = tbl[i].cr; push_receiver_in_reset = tbl[i].rx;
      #1;
      check($sformatf("row%0d req_ready", i), req_ready, tbl[i].rdy);
      check($sformatf("row%0d credit_count", i), credit_count, tbl[i].cnt);
      check($sformatf("row%0d push_valid", i), push_valid, tbl[i].pv);
      if (tbl[i].pv) check($sformatf("row%0d push_data", i), push_data, tbl[i].pd);
      check($sformatf("row%0d stall", i), push_credit_stall, tbl[i].stall);
      check($sformatf("row%0d sender_in_reset", i), push_sender_in_reset, tbl[i].sir);
      check($sformatf("row%0d state", i), fsm_state, tbl[i].st);
      check($sformatf("row%0d grant_id", i), grant_id, tbl[i].gid);
    end
`else
    // Requester 0 holds the link while it asks; the rest then rotate 1, 2, 3.
    do_reset();
    cycle(4'b0000, 32'hA3A2A1A0, 1'b0, 1'b0, g);
    cycle(4'b0000, 32'hA3A2A1A0, 1'b0, 1'b0, g);
    repeat (4) cycle(4'b0000, 32'hA3A2A1A0, 1'b1, 1'b0, g);
    for (int i = 0; i < 4; i++) begin
      cycle(4'b1111, 32'hA3A2A1A0, 1'b0, 1'b0, g);
      check($sformatf("prio grant%0d", i), req_ready, 4'b0001);
    end
    repeat (3) cycle(4'b0000, 32'hA3A2A1A0, 1'b1, 1'b0, g);
    for (int i = 1; i <= 3; i++) begin
      cycle(4'b1110, 32'hA3A2A1A0, 1'b0, 1'b0, g);
      check($sformatf("rotate grant%0d", i), req_ready, 32'd1 << i);
    end
`endif

    // Randomized run against the reference model, with one mid-run reset.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      rd = $urandom;
      cycle(4'($urandom_range(0, 15)), rd, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 29) == 0), g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/credit_link_arbiter.md
# credit_link_arbiter

Sender-side controller for a credit-flow link feeding a `credit_receiver`-style sink. It shares one `push_valid`/`push_data` channel among `NUM_REQ` requesters with round-robin arbitration. It tracks link credits returned on `push_credit` and sequences the link reset handshake. It sits between the local requesters and the link's push interface.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (≥2)
- `DATA_WIDTH`, 8, payload width
- `CREDIT_MAX`, 8, receiver buffer depth; maximum credits held (≥1)
- `CW`, `$clog2(CREDIT_MAX+1)`, credit counter width (derived)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-requester transfer request
- `req_data`  in  NUM_REQ*DATA_WIDTH  per-requester payload; requester i at `[i*DATA_WIDTH +: DATA_WIDTH]`
- `req_ready`  out  NUM_REQ  one-hot grant (combinational); transfer when `req_valid[i] & req_ready[i]`
- `push_valid`  out  1  registered link valid
- `push_data`  out  DATA_WIDTH  registered link payload
- `push_sender_in_reset`  out  1  sender-in-reset indication to receiver
- `push_receiver_in_reset`  in  1  receiver-in-reset indication
- `push_credit`  in  1  one-credit return pulse
- `push_credit_stall`  out  1  asks the receiver to hold credit returns
- `credit_count`  out  CW  credits currently held
- `grant_id`  out  $clog2(NUM_REQ)  index of last granted requester

## Operation
States: `RESET`, `WAIT`, `ACTIVE`.
- `rst_n` low: asynchronous entry to `RESET`. Outputs: `push_valid`=0, `push_data`=0, `credit_count`=0, `grant_id`=NUM_REQ-1, `push_sender_in_reset`=1, `push_credit_stall`=0, `req_ready`=0.
- `RESET` → `WAIT` on the first clock after `rst_n` is high.
- In `WAIT`, `push_sender_in_reset` drops to 0.
- `WAIT` → `ACTIVE` when `push_receiver_in_reset`=0.
- In `ACTIVE`, `push_receiver_in_reset`=1 forces `WAIT` on the next edge:
  - `credit_count` cleared to 0.
  - `push_valid` cleared.
  - No grant in that cycle.
- Credits start at 0. They build only from `push_credit` pulses (initial credits arrive as returns).
- Arbitration applies in `ACTIVE` when `credit_count` > 0:
  - Grant the first `req_valid` bit searching from `grant_id`+1 upward, modulo NUM_REQ.
  - Exactly one `req_ready` bit is high; all are low otherwise.
  - `grant_id` updates only on a grant.
- Counter update: next = count + `push_credit` − grant.
  - Return and send in the same cycle leave the count unchanged.
  - A return at `CREDIT_MAX` with no send saturates at `CREDIT_MAX` and is dropped.
- `push_credit_stall` = 1 when `credit_count` == CREDIT_MAX in `ACTIVE`.
- `push_credit` is ignored outside `ACTIVE`.

## Timing
- Grant in cycle N: `push_valid`=1 and `push_data`=granted payload in N+1. Otherwise `push_valid`=0 in N+1.
- Sustained throughput: one transfer per cycle while credits > 0.
- A credit returned in N is usable for a grant in N+1, not N.
- `credit_count` = 0 at cycle N: no grant in N, even if `push_credit`=1 in N.
- `credit_count` and `grant_id` change at N+1 after the event.
- `push_sender_in_reset` deasserts one cycle after the `rst_n` release edge.

## Configuration
- `CREDIT_ARB_PRIORITY_EN` defined: requester 0 is strict priority.
  - If `req_valid[0]` and credits > 0, grant requester 0.
  - Remaining requesters are round-robin among themselves.
  - `grant_id` is not updated by requester-0 grants.
- Not defined: pure round-robin across all NUM_REQ requesters, as above.

## Test plan
- Reset, then hold `push_receiver_in_reset`=1:
  - `push_sender_in_reset` = 1 → 0.
  - State stays `WAIT` and `req_ready`=0.
  - Release it, send 3 `push_credit` pulses → `credit_count`=3.
- 3 credits, all 4 `req_valid` high, data 0xA0..0xA3:
  - Grants 0, 1, 2 in order.
  - `push_data` = 0xA0, 0xA1, 0xA2 on consecutive cycles, one cycle after each grant.
  - `credit_count`=0, then no grant for requester 3.
- `credit_count`=0 with `push_credit` and `req_valid[1]` in the same cycle:
  - No grant in that cycle.
  - Grant to requester 1 next cycle; count ends at 0.
- Return 8 credits (`CREDIT_MAX`=8), then a 9th pulse:
  - Count stays 8.
  - `push_credit_stall`=1.
  - A simultaneous send+return holds the count at 8.
- With 5 credits, pulse `push_receiver_in_reset` mid-burst:
  - Next cycle `credit_count`=0, `push_valid`=0, state `WAIT`.
  - After release, arbitration resumes from the retained `grant_id`.
- With `CREDIT_ARB_PRIORITY_EN` and `req_valid`=4'b1111, 4 credits:
  - Grants 0, 0, 0, 0 while `req_valid[0]` stays high.
  - Drop it → grants rotate 1, 2, 3.
